id_ex_alu_ctrl: RTL and testbench
=================================

Name: id_ex_alu_ctrl

Overview:
- Main decode and ID/EX pipeline stage that produces the AluOp and fun6 fields consumed by the team's ALU control unit.
- Decodes RV32 opcode, funct3 and funct7 into classic two-bit AluOp plus a MIPS-style 6-bit funct, along with datapath control bits.
- Registers all of these into the ID/EX boundary.
- Also detects load-use hazards, inserts bubbles, honours flush and downstream stall, and counts illegal instructions.

Parameters:
- CNT_W, 8, width of saturating illegal-instruction counter
- FUN_DEFAULT, 6'h20, fun6 emitted when no R-type mapping applies (ADD)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_instr  in  32  instruction in ID
- ex_stall  in  1  EX cannot accept; hold ID/EX contents
- flush  in  1  kill ID/EX contents (branch taken)
- hazard_stall  out  1  combinational load-use stall request to IF/ID
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_aluop  out  2  AluOp to ALU control unit
- ex_fun6  out  6  funct field to ALU control unit
- ex_alusrc  out  1  ALU operand B = immediate
- ex_memread  out  1  load
- ex_memwrite  out  1  store
- ex_regwrite  out  1  writes rd
- ex_memtoreg  out  1  writeback from memory
- ex_branch  out  1  conditional branch
- ex_rd, ex_rs1, ex_rs2  out  5 each  register indices
- illegal  out  1  registered one-cycle pulse: illegal instruction entered EX
- illegal_count  out  CNT_W  saturating count of illegal instructions

Behaviour:
- Reset (async, rst_n=0): every output register cleared to 0. This includes ex_valid, all control bits, ex_aluop=00, ex_fun6=0, the indices, illegal and illegal_count. Reset mid-operation discards the in-flight instruction.
- Decode (combinational, on id_instr[6:0]); each entry lists AluOp, then alusrc/memread/memwrite/regwrite/memtoreg/branch:
  - 0110011 R-type: AluOp 10; 0/0/0/1/0/0
  - 0010011 ADDI, funct3=000 only: AluOp 00; 1/0/0/1/0/0
  - 0000011 LW, funct3=010: AluOp 00; 1/1/0/1/1/0
  - 0100011 SW, funct3=010: AluOp 00; 1/0/1/0/0/0
  - 1100011 BEQ, funct3=000: AluOp 01; 0/0/0/0/0/1
  - Anything else, including an unsupported funct3/funct7: illegal. All controls 0, AluOp 00.
- fun6 mapping, R-type only, keyed on {funct7, funct3}:
  - 0000000/000 -> 6'h20 (ADD)
  - 0100000/000 -> 6'h22 (SUB)
  - 0000000/111 -> 6'h24 (AND)
  - 0000000/110 -> 6'h25 (OR)
  - 0000000/010 -> 6'h2A (SLT)
  - Any other R-type combination: illegal.
  - All non-R-type instructions: fun6 = FUN_DEFAULT.
- Register indices: rd=[11:7], rs1=[19:15], rs2=[24:20]. Forced to 0 when the instruction does not use them: SW and BEQ have rd=0; LW and ADDI have rs2=0.
- hazard_stall = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((ex_rd==rs1) | (ex_rd==rs2)), using the decoded, zero-forced rs1/rs2.
- Register update priority, highest first:
  1. flush: load a bubble. A bubble is ex_valid=0 with all control bits, aluop, fun6 and indices 0. Flush beats ex_stall.
  2. ex_stall: hold all ID/EX registers. illegal pulse = 0.
  3. hazard_stall: load a bubble. The ID instruction is held upstream and re-presented next cycle.
  4. Otherwise: load the decoded ID instruction. ex_valid = id_valid & ~illegal_decode. If id_valid=0, load a bubble.
- Illegal handling, on a priority-4 load with id_valid=1 and illegal_decode=1:
  - The instruction is loaded as a bubble.
  - illegal = 1 for exactly that cycle.
  - illegal_count increments and saturates at all-ones.
- Latency: one cycle from ID presentation to EX outputs. hazard_stall has zero latency.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with id_valid=1 -> next cycle ex_valid=1, ex_aluop=10, ex_fun6=6'h20, regwrite=1, rd=3. The same instruction with funct7=0100000 (SUB) -> ex_fun6=6'h22.
- LW x5,0(x1), then ADD x6,x5,x2 -> while the LW is in EX, hazard_stall=1. The following cycle ex_valid=0 (bubble). The next cycle the ADD loads with rs1=5.
- LW x0 followed by a dependent use of x0 -> hazard_stall stays 0.
- ex_stall=1 for 3 cycles with BEQ in EX -> outputs unchanged (aluop=01, branch=1). Asserting flush together with ex_stall -> bubble next cycle.
- 300 consecutive illegal opcodes (0x0000007F) with CNT_W=8 -> an illegal pulse each load, illegal_count saturates at 255, ex_valid stays 0.
- rst_n low mid-stream, asynchronously between clock edges -> all outputs read 0 immediately. After rst_n rises, the first valid SW (0x0020A023) gives memwrite=1, alusrc=1, aluop=00, rd=0.

Source files
------------

// File: rtl/id_ex_alu_ctrl.sv
// rtl/id_ex_alu_ctrl.sv - RV32 subset main decode and ID/EX register feeding the ALU control unit
//
// Decodes opcode/funct3/funct7 of the ID instruction into a two-bit AluOp, a
// MIPS-style 6-bit funct and datapath control bits, then registers them into
// the ID/EX boundary. Detects load-use hazards (bubble insertion), honours
// flush and downstream stall, and counts illegal instructions.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_valid, id_instr    instruction presented by the ID stage
//   ex_stall              hold ID/EX contents
//   flush                 replace ID/EX contents with a bubble
//   hazard_stall          combinational load-use stall request to IF/ID
//   ex_valid              ID/EX holds a valid instruction
//   ex_aluop, ex_fun6     fields for the ALU control unit
//   ex_alusrc .. ex_branch datapath control bits
//   ex_rd, ex_rs1, ex_rs2 register indices (zeroed when unused)
//   illegal               one-cycle pulse when an illegal instruction reaches EX
//   illegal_count         saturating count of illegal instructions
module id_ex_alu_ctrl #(
    parameter int          CNT_W       = 8,
    parameter logic [5:0]  FUN_DEFAULT = 6'h20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic [1:0]       ex_aluop,
    output logic [5:0]       ex_fun6,
    output logic             ex_alusrc,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_regwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];

    logic       d_illegal;
    logic [1:0] d_aluop;
    logic [5:0] d_fun6;
    logic       d_alusrc, d_memread, d_memwrite, d_regwrite, d_memtoreg, d_branch;
    logic       use_rd, use_rs1, use_rs2;
    logic [4:0] d_rd, d_rs1, d_rs2;

    always_comb begin
        d_illegal  = 1'b1;
        d_aluop    = 2'b00;
        d_fun6     = FUN_DEFAULT;
        d_alusrc   = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_branch   = 1'b0;
        use_rd     = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        unique case (opcode)
            OP_R: begin
                d_illegal  = 1'b0;
                d_aluop    = 2'b10;
                d_regwrite = 1'b1;
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: d_fun6 = 6'h20;
                    10'b0100000_000: d_fun6 = 6'h22;
                    10'b0000000_111: d_fun6 = 6'h24;
                    10'b0000000_110: d_fun6 = 6'h25;
                    10'b0000000_010: d_fun6 = 6'h2A;
                    default:         d_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                d_illegal  = (funct3 != 3'b000);
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_LOAD: begin
                d_illegal  = (funct3 != 3'b010);
                d_alusrc   = 1'b1;
                d_memread  = 1'b1;
                d_regwrite = 1'b1;
                d_memtoreg = 1'b1;
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_STORE: begin
                d_illegal  = (funct3 != 3'b010);
                d_alusrc   = 1'b1;
                d_memwrite = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_BR: begin
                d_illegal  = (funct3 != 3'b000);
                d_aluop    = 2'b01;
                d_branch   = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            default: ;
        endcase
        // An illegal encoding uses no registers and drives no control, so it
        // can never raise a spurious load-use stall.
        if (d_illegal) begin
            d_aluop    = 2'b00;
            d_alusrc   = 1'b0;
            d_memread  = 1'b0;
            d_memwrite = 1'b0;
            d_regwrite = 1'b0;
            d_memtoreg = 1'b0;
            d_branch   = 1'b0;
            use_rd     = 1'b0;
            use_rs1    = 1'b0;
            use_rs2    = 1'b0;
        end
    end

    assign d_rd  = use_rd  ? id_instr[11:7]  : 5'd0;
    assign d_rs1 = use_rs1 ? id_instr[19:15] : 5'd0;
    assign d_rs2 = use_rs2 ? id_instr[24:20] : 5'd0;

    // Zero-forced indices mean an unused field never matches a nonzero ex_rd.
    assign hazard_stall = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                          ((ex_rd == d_rs1) | (ex_rd == d_rs2));

    logic load_decoded;
    assign load_decoded = id_valid & ~d_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_aluop      <= 2'b00;
            ex_fun6       <= 6'd0;
            ex_alusrc     <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_memtoreg   <= 1'b0;
            ex_branch     <= 1'b0;
            ex_rd         <= 5'd0;
            ex_rs1        <= 5'd0;
            ex_rs2        <= 5'd0;
            illegal       <= 1'b0;
            illegal_count <= '0;
        end else if (ex_stall && !flush) begin
            illegal <= 1'b0;
        end else begin
            // Flush, hazard bubble, idle ID and illegal decode all load a
            // bubble; only a legal valid instruction with no stall loads.
            if (!flush && !hazard_stall && load_decoded) begin
                ex_valid    <= 1'b1;
                ex_aluop    <= d_aluop;
                ex_fun6     <= d_fun6;
                ex_alusrc   <= d_alusrc;
                ex_memread  <= d_memread;
                ex_memwrite <= d_memwrite;
                ex_regwrite <= d_regwrite;
                ex_memtoreg <= d_memtoreg;
                ex_branch   <= d_branch;
                ex_rd       <= d_rd;
                ex_rs1      <= d_rs1;
                ex_rs2      <= d_rs2;
            end else begin
                ex_valid    <= 1'b0;
                ex_aluop    <= 2'b00;
                ex_fun6     <= 6'd0;
                ex_alusrc   <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memtoreg <= 1'b0;
                ex_branch   <= 1'b0;
                ex_rd       <= 5'd0;
                ex_rs1      <= 5'd0;
                ex_rs2      <= 5'd0;
            end
            if (!flush && !hazard_stall && id_valid && d_illegal) begin
                illegal <= 1'b1;
                if (illegal_count != {CNT_W{1'b1}})
                    illegal_count <= illegal_count + 1'b1;
            end else begin
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// tb/tb_id_ex_alu_ctrl.sv - self-checking bench for id_ex_alu_ctrl
module tb_id_ex_alu_ctrl;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             ex_stall;
    logic             flush;
    logic             hazard_stall;
    logic             ex_valid;
    logic [1:0]       ex_aluop;
    logic [5:0]       ex_fun6;
    logic             ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    always #5 clk = ~clk;

    id_ex_alu_ctrl #(.CNT_W(CNT_W), .FUN_DEFAULT(6'h20)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_stall(ex_stall), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_fun6(ex_fun6),
        .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    // {valid, aluop, fun6, alusrc, memread, memwrite, regwrite, memtoreg, branch, rd, rs1, rs2, illegal}
    logic [30:0] dut_vec;
    assign dut_vec = {ex_valid, ex_aluop, ex_fun6, ex_alusrc, ex_memread, ex_memwrite,
                      ex_regwrite, ex_memtoreg, ex_branch, ex_rd, ex_rs1, ex_rs2, illegal};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       legal;
        logic [1:0] aluop;
        logic [5:0] fun6;
        logic [5:0] ctrl;   // alusrc memread memwrite regwrite memtoreg branch
        logic [4:0] rd, rs1, rs2;
    } dec_t;

    // Instruction classes: 0 illegal, 1 R, 2 ADDI, 3 LW, 4 SW, 5 BEQ
    function automatic int classify(input logic [31:0] ins);
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        if (op == 7'h33 && ((f7 == 7'h00 && (f3 == 0 || f3 == 7 || f3 == 6 || f3 == 2)) ||
                            (f7 == 7'h20 && f3 == 0))) return 1;
        if (op == 7'h13 && f3 == 0) return 2;
        if (op == 7'h03 && f3 == 2) return 3;
        if (op == 7'h23 && f3 == 2) return 4;
        if (op == 7'h63 && f3 == 0) return 5;
        return 0;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int   k;
        // per class: aluop, ctrl bits, and which of rd/rs1/rs2 are used
        logic [1:0] aop_t [6] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [5:0] ctl_t [6] = '{6'b000000, 6'b000100, 6'b100100, 6'b110110, 6'b101000, 6'b000001};
        logic [2:0] use_t [6] = '{3'b000, 3'b111, 3'b110, 3'b110, 3'b011, 3'b011};
        k = classify(ins);
        d.legal = (k != 0);
        d.aluop = aop_t[k];
        d.ctrl  = ctl_t[k];
        d.rd    = use_t[k][2] ? ins[11:7]  : 5'd0;
        d.rs1   = use_t[k][1] ? ins[19:15] : 5'd0;
        d.rs2   = use_t[k][0] ? ins[24:20] : 5'd0;
        d.fun6  = 6'h20;
        if (k == 1) begin
            if (ins[30])             d.fun6 = 6'h22;
            else if (ins[14:12] == 7) d.fun6 = 6'h24;
            else if (ins[14:12] == 6) d.fun6 = 6'h25;
            else if (ins[14:12] == 2) d.fun6 = 6'h2A;
        end
        return d;
    endfunction

    logic [30:0] m_vec = '0;
    int          m_cnt = 0;

    function automatic logic model_hazard(input logic v, input logic [31:0] ins);
        dec_t d;
        d = ref_decode(ins);
        return m_vec[30] && m_vec[20] && m_vec[15:11] != 0 && v &&
               (m_vec[15:11] == d.rs1 || m_vec[15:11] == d.rs2);
    endfunction

    task automatic model_clock(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        dec_t d;
        logic hz;
        d  = ref_decode(ins);
        hz = model_hazard(v, ins);
        if (!rst_n) begin
            m_vec = '0; m_cnt = 0;
        end else if (fl) begin
            m_vec = '0;
        end else if (st) begin
            m_vec[0] = 1'b0;
        end else if (hz || !v) begin
            m_vec = '0;
        end else if (!d.legal) begin
            m_vec = 31'd1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_vec = {1'b1, d.aluop, d.fun6, d.ctrl, d.rd, d.rs1, d.rs2, 1'b0};
        end
    endtask

    // One cycle: drive on the falling edge, check the combinational stall,
    // clock, then check registered outputs shortly after the rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic st,
                        input logic fl, output logic hz);
        @(negedge clk);
        id_valid = v; id_instr = ins; ex_stall = st; flush = fl;
        #1;
        hz = hazard_stall;
        check("hazard_stall", {31'd0, hazard_stall}, {31'd0, model_hazard(v, ins)});
        @(posedge clk);
        model_clock(v, ins, st, fl);
        #1;
        check("ex_state", {1'b0, dut_vec}, {1'b0, m_vec});
        check("illegal_count", 32'(illegal_count), 32'(m_cnt));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [30:0] exp;
    } vec_t;

    function automatic logic [30:0] mk(input logic v, input logic [1:0] a, input logic [5:0] f,
                                       input logic [5:0] c, input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2, input logic il);
        return {v, a, f, c, rd, r1, r2, il};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, r1, r2;
        logic [31:0] r;
        logic [2:0] f3s [5] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd2};
        int k;
        rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
        r  = $urandom;
        case ($urandom_range(0, 7))
            0: begin
                k = $urandom_range(0, 4);
                return {(k == 1) ? 7'h20 : 7'h00, r2, r1, f3s[k], rd, 7'h33};
            end
            1: return {r[31:20], r1, 3'd0, rd, 7'h13};
            2: return {r[31:20], r1, 3'd2, rd, 7'h03};
            3: return {r[31:25], r2, r1, 3'd2, r[11:7], 7'h23};
            4: return {r[31:25], r2, r1, 3'd0, r[11:7], 7'h63};
            5: return {r[31:25], r2, r1, r[14:12], rd, 7'h33};
            6: return {r[31:15], r[14:12], rd, 7'h03};
            default: return r;
        endcase
    endfunction

    vec_t tbl [14];
    logic hz;

    initial begin
        tbl[0]  = '{"add",      32'h002081B3, mk(1, 2'b10, 6'h20, 6'b000100, 3, 1, 2, 0)};
        tbl[1]  = '{"sub",      32'h402081B3, mk(1, 2'b10, 6'h22, 6'b000100, 3, 1, 2, 0)};
        tbl[2]  = '{"and",      32'h0020F1B3, mk(1, 2'b10, 6'h24, 6'b000100, 3, 1, 2, 0)};
        tbl[3]  = '{"or",       32'h0020E1B3, mk(1, 2'b10, 6'h25, 6'b000100, 3, 1, 2, 0)};
        tbl[4]  = '{"slt",      32'h0020A1B3, mk(1, 2'b10, 6'h2A, 6'b000100, 3, 1, 2, 0)};
        tbl[5]  = '{"sll_ill",  32'h002091B3, mk(0, 2'b00, 6'h00, 6'b000000, 0, 0, 0, 1)};
        tbl[6]  = '{"addi",     32'h00708293, mk(1, 2'b00, 6'h20, 6'b100100, 5, 1, 0, 0)};
        tbl[7]  = '{"slli_ill", 32'h00709293, mk(0, 2'b00, 6'h00, 6'b000000, 0, 0, 0, 1)};
        tbl[8]  = '{"lw",       32'h0000A283, mk(1, 2'b00, 6'h20, 6'b110110, 5, 1, 0, 0)};
        tbl[9]  = '{"lb_ill",   32'h00008283, mk(0, 2'b00, 6'h00, 6'b000000, 0, 0, 0, 1)};
        tbl[10] = '{"sw",       32'h0020A023, mk(1, 2'b00, 6'h20, 6'b101000, 0, 1, 2, 0)};
        tbl[11] = '{"beq",      32'h00208063, mk(1, 2'b01, 6'h20, 6'b000001, 0, 1, 2, 0)};
        tbl[12] = '{"bne_ill",  32'h00209063, mk(0, 2'b00, 6'h00, 6'b000000, 0, 0, 0, 1)};
        tbl[13] = '{"op7f_ill", 32'h0000007F, mk(0, 2'b00, 6'h00, 6'b000000, 0, 0, 0, 1)};

        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("reset_state", {1'b0, dut_vec}, 32'd0);
        check("reset_count", 32'(illegal_count), 32'd0);

        foreach (tbl[i]) begin
            step(1, tbl[i].instr, 0, 0, hz);
            check(tbl[i].name, {1'b0, dut_vec}, {1'b0, tbl[i].exp});
            step(0, 32'h0, 0, 0, hz);
        end

        // load-use: LW x5 then ADD x6,x5,x2
        step(1, 32'h0000A283, 0, 0, hz);
        step(1, 32'h00228333, 0, 0, hz);
        check("lu_stall", {31'd0, hz}, 32'd1);
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step(1, 32'h00228333, 0, 0, hz);
        check("lu_nostall", {31'd0, hz}, 32'd0);
        check("lu_add_rs1", {27'd0, ex_rs1}, 32'd5);
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);

        // LW x0 followed by a use of x0 never stalls
        step(1, 32'h0000A003, 0, 0, hz);
        step(1, 32'h00200333, 0, 0, hz);
        check("lw_x0_nostall", {31'd0, hz}, 32'd0);

        // hold BEQ in EX for 3 stalled cycles, then flush beats stall
        step(1, 32'h00208063, 0, 0, hz);
        repeat (3) step(1, 32'h002081B3, 1, 0, hz);
        check("stall_aluop", {30'd0, ex_aluop}, 32'd1);
        check("stall_branch", {31'd0, ex_branch}, 32'd1);
        check("stall_valid", {31'd0, ex_valid}, 32'd1);
        step(1, 32'h002081B3, 1, 1, hz);
        check("flush_stall", {1'b0, dut_vec}, 32'd0);

        // 300 illegal opcodes: pulse every load, counter saturates
        for (int i = 0; i < 300; i++) begin
            step(1, 32'h0000007F, 0, 0, hz);
            check("ill_pulse", {31'd0, illegal}, 32'd1);
        end
        check("ill_saturate", 32'(illegal_count), CNT_MAX);
        check("ill_valid", {31'd0, ex_valid}, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, hz);

        // async reset between edges
        step(1, 32'h0000A283, 0, 0, hz);
        @(negedge clk); #2; rst_n = 1'b0;
        #1;
        check("async_rst_vec", {1'b0, dut_vec}, 32'd0);
        check("async_rst_count", 32'(illegal_count), 32'd0);
        check("async_rst_hz", {31'd0, hazard_stall}, 32'd0);
        m_vec = '0; m_cnt = 0;
        id_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step(1, 32'h0020A023, 0, 0, hz);
        check("post_rst_sw", {1'b0, dut_vec}, {1'b0, mk(1, 2'b00, 6'h20, 6'b101000, 0, 1, 2, 0)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
